// File: rtl/keypad_scanner_if.sv
// Signal bundle between the keypad scanner, the 4x4 key matrix and the character consumer.
// The scanner drives the columns and the character strobe; the environment drives the rows.
interface keypad_scanner_if;
  logic [3:0] row_n;
  logic [3:0] col_n;
  logic [7:0] char_out;
  logic       send;
  logic       key_down;

  modport master (
    input  row_n,
    output col_n,
    output char_out,
    output send,
    output key_down
  );

  modport slave (
    output row_n,
    input  col_n,
    input  char_out,
    input  send,
    input  key_down
  );
endinterface

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: column walk, per-key debounce of press and release,
// one ASCII strobe per accepted press and a key_down level while the key is held.
module keypad_scanner #(
  parameter int SCAN_DIV = 1000,
  parameter int DEB_CNT  = 20
) (
  input  logic              clk,
  input  logic              rst_n,
  keypad_scanner_if.master  kif
);

  localparam int TICK_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int CNT_W  = $clog2(DEB_CNT + 1);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0]  CNT_DONE  = CNT_W'(DEB_CNT);

  typedef enum logic [2:0] {
    ST_SCAN     = 3'd0,
    ST_DEBOUNCE = 3'd1,
    ST_PRESSED  = 3'd2,
    ST_HOLD     = 3'd3,
    ST_RELEASE  = 3'd4
  } state_t;

  state_t             state_r;
  logic [3:0]         row_meta_r;
  logic [3:0]         row_sync_r;
  logic [TICK_W-1:0]  tick_cnt_r;
  logic [CNT_W-1:0]   cnt_r;
  logic [1:0]         col_r;
  logic [1:0]         row_idx_r;
  logic [3:0]         col_n_r;
  logic [7:0]         char_r;
  logic               send_r;
  logic               key_down_r;

  logic               tick_s;
  logic               any_low_s;
  logic               row_hit_s;
  logic [CNT_W-1:0]   cnt_inc_s;
  logic [1:0]         col_next_s;

  // Lowest-index active (low) row wins when several keys share a column.
  function automatic logic [1:0] low_row_idx(input logic [3:0] rows_n);
    logic [1:0] idx;
    casez (rows_n)
      4'b???0: idx = 2'd0;
      4'b??01: idx = 2'd1;
      4'b?011: idx = 2'd2;
      default: idx = 2'd3;
    endcase
    return idx;
  endfunction

  function automatic logic [3:0] col_drive(input logic [1:0] col);
    return ~(4'b0001 << col);
  endfunction

  function automatic logic [7:0] key_ascii(input logic [1:0] row, input logic [1:0] col);
    logic [7:0] code;
    case ({row, col})
      4'h0:    code = 8'h31;  // 1
      4'h1:    code = 8'h32;  // 2
      4'h2:    code = 8'h33;  // 3
      4'h3:    code = 8'h41;  // A
      4'h4:    code = 8'h34;  // 4
      4'h5:    code = 8'h35;  // 5
      4'h6:    code = 8'h36;  // 6
      4'h7:    code = 8'h42;  // B
      4'h8:    code = 8'h37;  // 7
      4'h9:    code = 8'h38;  // 8
      4'hA:    code = 8'h39;  // 9
      4'hB:    code = 8'h43;  // C
      4'hC:    code = 8'h2A;  // *
      4'hD:    code = 8'h30;  // 0
      4'hE:    code = 8'h23;  // #
      default: code = 8'h44;  // D
    endcase
    return code;
  endfunction

  assign tick_s     = (tick_cnt_r == TICK_LAST);
  assign any_low_s  = ~(&row_sync_r);
  assign row_hit_s  = ~row_sync_r[row_idx_r];
  assign cnt_inc_s  = cnt_r + CNT_W'(1);
  assign col_next_s = col_r + 2'd1;

  // Two-flop synchronizer for the asynchronous row inputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_meta_r <= 4'b1111;
      row_sync_r <= 4'b1111;
    end else begin
      row_meta_r <= kif.row_n;
      row_sync_r <= row_meta_r;
    end
  end

  // Sample-period divider; rows are only evaluated on the wrap cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt_r <= TICK_W'(0);
    end else if (tick_s) begin
      tick_cnt_r <= TICK_W'(0);
    end else begin
      tick_cnt_r <= tick_cnt_r + TICK_W'(1);
    end
  end

  // Scan / debounce FSM with registered column drive and character outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_SCAN;
      cnt_r      <= CNT_W'(0);
      col_r      <= 2'd0;
      row_idx_r  <= 2'd0;
      col_n_r    <= 4'b1110;
      char_r     <= 8'h00;
      send_r     <= 1'b0;
      key_down_r <= 1'b0;
    end else begin
      send_r <= 1'b0;
      case (state_r)
        ST_SCAN: begin
          if (tick_s) begin
            if (any_low_s) begin
              row_idx_r <= low_row_idx(row_sync_r);
              cnt_r     <= CNT_W'(0);
              state_r   <= ST_DEBOUNCE;
            end else begin
              col_r   <= col_next_s;
              col_n_r <= col_drive(col_next_s);
            end
          end
        end
        ST_DEBOUNCE: begin
          if (tick_s) begin
            if (!row_hit_s) begin
              cnt_r   <= CNT_W'(0);
              state_r <= ST_SCAN;
            end else if (cnt_inc_s >= CNT_DONE) begin
              // Outputs load on entry so the strobe is high during the PRESSED cycle.
              cnt_r      <= CNT_W'(0);
              char_r     <= key_ascii(row_idx_r, col_r);
              send_r     <= 1'b1;
              key_down_r <= 1'b1;
              state_r    <= ST_PRESSED;
            end else begin
              cnt_r <= cnt_inc_s;
            end
          end
        end
        ST_PRESSED: begin
          state_r <= ST_HOLD;
        end
        ST_HOLD: begin
          if (tick_s && !row_hit_s) begin
            if (CNT_W'(1) >= CNT_DONE) begin
              cnt_r      <= CNT_W'(0);
              key_down_r <= 1'b0;
              col_r      <= col_next_s;
              col_n_r    <= col_drive(col_next_s);
              state_r    <= ST_SCAN;
            end else begin
              cnt_r   <= CNT_W'(1);
              state_r <= ST_RELEASE;
            end
          end
        end
        ST_RELEASE: begin
          if (tick_s) begin
            if (row_hit_s) begin
              cnt_r   <= CNT_W'(0);
              state_r <= ST_HOLD;
            end else if (cnt_inc_s >= CNT_DONE) begin
              cnt_r      <= CNT_W'(0);
              key_down_r <= 1'b0;
              col_r      <= col_next_s;
              col_n_r    <= col_drive(col_next_s);
              state_r    <= ST_SCAN;
            end else begin
              cnt_r <= cnt_inc_s;
            end
          end
        end
        default: begin
          state_r    <= ST_SCAN;
          cnt_r      <= CNT_W'(0);
          col_r      <= 2'd0;
          col_n_r    <= 4'b1110;
          key_down_r <= 1'b0;
        end
      endcase
    end
  end

  assign kif.col_n    = col_n_r;
  assign kif.char_out = char_r;
  assign kif.send     = send_r;
  assign kif.key_down = key_down_r;

endmodule

// File: doc/keypad_scanner.md
KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 1000, clk cycles per column dwell/sample period (1 ms at 1 MHz).
REQ-002 SHALL have parameter DEB_CNT, default 20, consecutive matching samples to accept a press or release.
REQ-003 SHALL have port clk  input  1  system clock, 1 MHz.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port row_n  input  4  keypad rows, active-low, externally pulled up, asynchronous to clk.
REQ-006 SHALL have port col_n  output  4  keypad column drive, active-low, exactly one bit low at any time.
REQ-007 SHALL have port char_out  output  8  ASCII code of the last accepted key, held until the next press.
REQ-008 SHALL have port send  output  1  single-cycle strobe, char_out valid in the same cycle; feeds the LCD char_in/send inputs.
REQ-009 SHALL have port key_down  output  1  high from press acceptance until release acceptance.

Function
REQ-010 SHALL pass row_n through a 2-flop synchronizer; all decisions use the synchronized value only.
REQ-011 SHALL run a sample tick every SCAN_DIV cycles (counter 0..SCAN_DIV-1, wrap); rows are evaluated only on a tick, so column settle time is SCAN_DIV-1 cycles.
REQ-012 SHALL implement FSM states SCAN, DEBOUNCE, PRESSED, HOLD, RELEASE.
REQ-013 SCAN: on tick with all rows high, advance column 0->1->2->3->0 (col_n 1110, 1101, 1011, 0111); on tick with any row low, latch column and lowest-index low row, go to DEBOUNCE, column unchanged.
REQ-014 DEBOUNCE: column held; on each tick, if latched row still low, increment match count; on reaching DEB_CNT go to PRESSED; if latched row high, clear count and return to SCAN on same column.
REQ-015 PRESSED: lasts exactly one cycle; SHALL load char_out, assert send for that cycle, set key_down, go to HOLD.
REQ-016 HOLD: column held; on tick with latched row high, go to RELEASE with count 1; no further send while held (no auto-repeat).
REQ-017 RELEASE: on tick with latched row high increment count, at DEB_CNT clear key_down and go to SCAN on next column; on tick with latched row low return to HOLD, count cleared.
REQ-018 SHALL ignore presses in other columns and other rows of the latched column from DEBOUNCE through RELEASE.
REQ-019 Key map (row,col)->ASCII: r0 "1","2","3","A"; r1 "4","5","6","B"; r2 "7","8","9","C"; r3 "*","0","#","D".
REQ-020 Press-to-send latency SHALL be DEB_CNT ticks after first detecting tick, plus 1 cycle; send SHALL never be high on two consecutive cycles.
REQ-021 Simultaneous keys in one column at detection: lowest row index wins; keys in different columns: first column scanned wins.

Reset
REQ-022 While rst_n low: state SCAN, column 0 (col_n=1110), tick counter 0, match count 0, synchronizer flops 1111, char_out 8'h00, send 0, key_down 0.
REQ-023 Reset asserted mid-debounce, hold or release SHALL abandon the key with no send; scanning restarts at column 0 after release.

Verification
REQ-024 Hold key r1c1 stable 100 ms -> exactly one send, char_out=8'h35, key_down high until release debounced.
REQ-025 Bounce r0c0 low for 5 ticks then high -> no send, char_out unchanged, scanning resumes on column 0.
REQ-026 Press r3c1, release 30 ms, press again -> two sends, each with char_out=8'h30, key_down drops between.
REQ-027 Press r1c2 and r3c2 together -> single send, char_out=8'h36; add r0c0 while held -> no send.
REQ-028 No keys, run 5 ms -> col_n sequence 1110,1101,1011,0111,1110 at SCAN_DIV intervals, send never high.
REQ-029 Assert rst_n low during HOLD of r2c3 -> char_out=8'h00, send 0, key_down 0 immediately, col_n=1110.
